ddr_arbiter: RTL and testbench

Single-port DDR access arbiter between the instruction cache, data cache and context-store requesters and the DDR burst interface module. Grants one requester at a time, issues one fixed-length read or write burst on its behalf, and routes beat handshakes and data back to the granted requester only. Sits between the cache blocks and the DDR interface module, replacing direct point-to-point request wiring.

---
 rtl/ddr_arbiter_pkg.sv | 39 +++
 rtl/ddr_arb_pick.sv | 26 ++
 rtl/ddr_arbiter.sv | 158 +++++++++++++++
 tb/tb_ddr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arbiter_pkg.sv
// Shared types and constants for the DDR access arbiter.
// State encoding, requester indices and the burst-length field width.
package ddr_arbiter_pkg;

  localparam int LEN_W   = 10;
  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_INS  = 2'd0;
  localparam logic [1:0] REQ_DATA = 2'd1;
  localparam logic [1:0] REQ_CTXT = 2'd2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    ARB      = S_ARB,
    RD_BURST = S_RD,
    WR_BURST = S_WR,
    DONE     = S_DONE
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    case (idx)
      REQ_INS:  return 3'b001;
      REQ_DATA: return 3'b010;
      REQ_CTXT: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    return oh[2] ? REQ_CTXT : (oh[1] ? REQ_DATA : REQ_INS);
  endfunction

endpackage

// File: rtl/ddr_arb_pick.sv
// Combinational 3-way picker: searches start, start-1, start-2 (mod 3).
// Zero latency; no backpressure, pure function of its inputs.
module ddr_arb_pick
  import ddr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         start,
  output logic [NUM_REQ-1:0] win
);

  logic [1:0] o0, o1, o2;

  // Start at the pointer and walk downward so that start=2 is plain 2 > 1 > 0.
  always_comb begin
    case (start)
      REQ_INS:  {o0, o1, o2} = {REQ_INS,  REQ_CTXT, REQ_DATA};
      REQ_DATA: {o0, o1, o2} = {REQ_DATA, REQ_INS,  REQ_CTXT};
      default:  {o0, o1, o2} = {REQ_CTXT, REQ_DATA, REQ_INS};
    endcase
    win = '0;
    if (req[o0])      win = idx_to_onehot(o0);
    else if (req[o1]) win = idx_to_onehot(o1);
    else if (req[o2]) win = idx_to_onehot(o2);
  end

endmodule

// File: rtl/ddr_arbiter.sv
// Single-port DDR burst arbiter for icache/dcache/context store; DDR_ARB_RR_EN selects round-robin.
// Latency: grant and burst request two cycles after the request is seen in IDLE; beats route combinationally.
// Backpressure: requests are level-held and only sampled in IDLE; beats past BURST_LEN are dropped and flag err.
module ddr_arbiter
  import ddr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int BURST_LEN      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_rd,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [LEN_W-1:0]                rd_cnt,
  output logic [NUM_REQ-1:0]              wr_data_req,
  output logic [NUM_REQ-1:0]              done,
  output logic                            err,
  output logic                            rd_burst_req,
  output logic                            wr_burst_req,
  output logic [LEN_W-1:0]                rd_burst_len,
  output logic [LEN_W-1:0]                wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]       rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0]       wr_burst_addr,
  output logic [DATA_WIDTH-1:0]           wr_burst_data,
  input  logic [DATA_WIDTH-1:0]           rd_burst_data,
  input  logic                            rd_burst_data_valid,
  input  logic                            wr_burst_data_req,
  input  logic                            rd_burst_finish,
  input  logic                            wr_burst_finish
);

  localparam logic [LEN_W-1:0] BLEN = LEN_W'(BURST_LEN);

  state_t                    state, state_n;
  logic [1:0]                idx;
  logic                      is_wr;
  logic [DDR_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]          cnt;
  logic                      err_q;

  logic [NUM_REQ-1:0]        req_any, win, gnt_oh;
  logic [1:0]                start, win_idx;
  logic                      beat_in, room, take;
  logic [DDR_ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]     wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_arr[i]  = req_addr[i*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req_any = req_rd | req_wr;
  assign take    = (state == IDLE) && (|req_any);
  assign win_idx = onehot_to_idx(win);
  assign gnt_oh  = idx_to_onehot(idx);
  assign beat_in = ((state == RD_BURST) && rd_burst_data_valid) ||
                   ((state == WR_BURST) && wr_burst_data_req);
  assign room    = (cnt < BLEN);

`ifdef DDR_ARB_RR_EN
  logic [1:0] last;

  // Reset value 2 makes requester 0 the first one searched.
  always_ff @(posedge clk) begin
    if (rst)       last <= REQ_CTXT;
    else if (take) last <= win_idx;
  end

  assign start = (last == REQ_CTXT) ? REQ_INS : last + 2'd1;
`else
  assign start = REQ_CTXT;
`endif

  ddr_arb_pick u_pick (
    .req   (req_any),
    .start (start),
    .win   (win)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    gnt           = '0;
    done          = '0;
    rd_valid      = '0;
    wr_data_req   = '0;
    rd_burst_req  = 1'b0;
    wr_burst_req  = 1'b0;
    rd_data       = '0;
    wr_burst_data = '0;
    case (state)
      IDLE: if (|req_any) state_n = ARB;
      ARB:  state_n = is_wr ? WR_BURST : RD_BURST;
      RD_BURST: begin
        gnt          = gnt_oh;
        rd_burst_req = 1'b1;
        rd_data      = rd_burst_data;
        if (rd_burst_data_valid && room) rd_valid = gnt_oh;
        if (rd_burst_finish) state_n = DONE;
      end
      WR_BURST: begin
        gnt           = gnt_oh;
        wr_burst_req  = 1'b1;
        wr_burst_data = wdata_arr[idx];
        if (wr_burst_data_req && room) wr_data_req = gnt_oh;
        if (wr_burst_finish) state_n = DONE;
      end
      DONE: begin
        gnt     = gnt_oh;
        done    = gnt_oh;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Winner is captured in IDLE, its address one cycle later in ARB.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= REQ_INS;
      is_wr  <= 1'b0;
      addr_q <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (take) begin
        idx   <= win_idx;
        is_wr <= req_wr[win_idx];
      end
      if (state == ARB) begin
        addr_q <= addr_arr[idx];
        cnt    <= '0;
      end
      if (beat_in) begin
        if (room) cnt   <= cnt + LEN_W'(1);
        else      err_q <= 1'b1;
      end
    end
  end

  assign rd_cnt        = cnt;
  assign err           = err_q;
  assign rd_burst_len  = BLEN;
  assign wr_burst_len  = BLEN;
  assign rd_burst_addr = addr_q;
  assign wr_burst_addr = addr_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Scoreboard bench for ddr_arbiter: the bench plays the DDR interface and the three requesters.
module tb_ddr_arbiter;

  localparam int DW = 16;
  localparam int AW = 28;
  localparam int BL = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      req_rd = '0, req_wr = '0;
  logic [3*AW-1:0] req_addr = '0;
  logic [3*DW-1:0] req_wdata = '0;
  logic [DW-1:0]   rd_burst_data = '0;
  logic            rd_burst_data_valid = 1'b0, wr_burst_data_req = 1'b0;
  logic            rd_burst_finish = 1'b0, wr_burst_finish = 1'b0;

  logic [2:0]      gnt, rd_valid, wr_data_req, done;
  logic [DW-1:0]   rd_data, wr_burst_data;
  logic [9:0]      rd_cnt, rd_burst_len, wr_burst_len;
  logic            err, rd_burst_req, wr_burst_req;
  logic [AW-1:0]   rd_burst_addr, wr_burst_addr;

  typedef struct {
    logic [2:0]    vld;
    logic [DW-1:0] dat;
    logic [9:0]    cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  ddr_arbiter #(.DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_cnt(rd_cnt),
    .wr_data_req(wr_data_req), .done(done), .err(err),
    .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
    .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .rd_burst_data(rd_burst_data),
    .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] oh(input int i);
    oh = 3'b001 << i;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Called in the cycle a request becomes visible in IDLE; returns in the grant cycle.
  task automatic expect_grant(input string name, input int idx, input bit wr, input logic [AW-1:0] addr);
    tick;
    mid;
    checks++;
    if (gnt !== 3'b000 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin
      failures++;
      $display("FAIL %s early_grant: gnt=%b rd_req=%b wr_req=%b, want all 0", name, gnt, rd_burst_req, wr_burst_req);
    end
    tick;
    mid;
    checks++;
    if (gnt !== oh(idx) || wr_burst_req !== wr || rd_burst_req !== !wr ||
        (wr ? wr_burst_addr : rd_burst_addr) !== addr) begin
      failures++;
      $display("FAIL %s grant: gnt=%b rd_req=%b wr_req=%b addr=%h, want gnt=%b wr=%0d addr=%h",
               name, gnt, rd_burst_req, wr_burst_req, wr ? wr_burst_addr : rd_burst_addr, oh(idx), wr, addr);
    end
  endtask

  // DDR-side model: delivers nbeats, optionally a wrong-direction finish first, optionally the finish.
  task automatic serve_burst(input string name, input bit wr, input int idx, input int nbeats,
                             input bit spurious, input bit fin);
    exp_t e, g;
    logic [2:0] other;
    if (spurious) begin
      tick;
      if (wr) rd_burst_finish = 1'b1;
      else    wr_burst_finish = 1'b1;
      mid;
      tick;
      rd_burst_finish = 1'b0;
      wr_burst_finish = 1'b0;
      mid;
      checks++;
      if ((wr ? wr_burst_req : rd_burst_req) !== 1'b1 || done !== 3'b000) begin
        failures++;
        $display("FAIL %s spurious_finish: burst_req=%b done=%b, want 1 and 000",
                 name, wr ? wr_burst_req : rd_burst_req, done);
      end
    end
    for (int b = 0; b < nbeats; b++) begin
      tick;
      e.vld = (b < BL) ? oh(idx) : 3'b000;
      e.cnt = (b < BL) ? 10'(b) : 10'(BL);
      if (wr) begin
        wr_burst_data_req = 1'b1;
        req_wdata = 48'({$urandom, $urandom});
        e.dat = req_wdata[idx*DW +: DW];
      end else begin
        rd_burst_data_valid = 1'b1;
        rd_burst_data = 16'($urandom);
        e.dat = rd_burst_data;
      end
      sb.push_back(e);
      mid;
      g = sb.pop_front();
      e.vld = wr ? wr_data_req : rd_valid;
      e.dat = wr ? wr_burst_data : rd_data;
      other = wr ? rd_valid : wr_data_req;
      checks++;
      if (e.vld !== g.vld || other !== 3'b000) begin
        failures++;
        $display("FAIL %s beat%0d_route: got %b (other %b), want %b (other 000)", name, b, e.vld, other, g.vld);
      end
      if (g.vld != 3'b000) begin
        checks++;
        if (e.dat !== g.dat || (!wr && rd_cnt !== g.cnt)) begin
          failures++;
          $display("FAIL %s beat%0d_data: got data=%h cnt=%0d, want data=%h cnt=%0d",
                   name, b, e.dat, rd_cnt, g.dat, g.cnt);
        end
      end
    end
    tick;
    rd_burst_data_valid = 1'b0;
    wr_burst_data_req = 1'b0;
    if (!fin) return;
    if (wr) wr_burst_finish = 1'b1;
    else    rd_burst_finish = 1'b1;
    mid;
    tick;
    rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0;
    mid;
    checks++;
    if (done !== oh(idx) || gnt !== oh(idx)) begin
      failures++;
      $display("FAIL %s done_pulse: done=%b gnt=%b, want %b", name, done, gnt, oh(idx));
    end
    tick;
    mid;
    checks++;
    if (gnt !== 3'b000 || done !== 3'b000) begin
      failures++;
      $display("FAIL %s release: gnt=%b done=%b, want 000", name, gnt, done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_rd = 3'b111;
    rd_burst_data_valid = 1'b1;
    tick;
    tick;
    mid;
    checks++;
    if ({gnt, rd_valid, wr_data_req, done, err, rd_burst_req, wr_burst_req} !== 15'd0) begin
      failures++;
      $display("FAIL reset_ctrl: gnt=%b rd_valid=%b wr_data_req=%b done=%b err=%b rreq=%b wreq=%b, want 0",
               gnt, rd_valid, wr_data_req, done, err, rd_burst_req, wr_burst_req);
    end
    checks++;
    if ({rd_data, rd_cnt, wr_burst_data, rd_burst_addr, wr_burst_addr} !== '0) begin
      failures++;
      $display("FAIL reset_data: rd_data=%h rd_cnt=%0d wdata=%h raddr=%h waddr=%h, want 0",
               rd_data, rd_cnt, wr_burst_data, rd_burst_addr, wr_burst_addr);
    end
    checks++;
    if (rd_burst_len !== 10'd16 || wr_burst_len !== 10'd16) begin
      failures++;
      $display("FAIL reset_len: rd_len=%0d wr_len=%0d, want 16", rd_burst_len, wr_burst_len);
    end
    req_rd = 3'b000;
    rd_burst_data_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    tick;
    set_addr(1, 28'h0000500);
    req_rd = 3'b010;
    expect_grant("single_read", 1, 1'b0, 28'h0000500);
    req_rd = 3'b000;
    serve_burst("single_read", 1'b0, 1, 16, 1'b0, 1'b1);
  endtask

  task automatic test_priority;
    tick;
    set_addr(0, 28'h0001111);
    set_addr(2, 28'h0002222);
    req_rd = 3'b001;
    req_wr = 3'b100;
    expect_grant("prio_ctxt_wr", 2, 1'b1, 28'h0002222);
    req_wr = 3'b000;
    serve_burst("prio_ctxt_wr", 1'b1, 2, 16, 1'b0, 1'b1);
    expect_grant("prio_ins_rd", 0, 1'b0, 28'h0001111);
    req_rd = 3'b000;
    serve_burst("prio_ins_rd", 1'b0, 0, 4, 1'b0, 1'b1);
    tick;
    set_addr(1, 28'h0003333);
    req_rd = 3'b010;
    req_wr = 3'b010;
    expect_grant("wr_over_rd", 1, 1'b1, 28'h0003333);
    req_rd = 3'b000;
    req_wr = 3'b000;
    serve_burst("wr_over_rd", 1'b1, 1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_round_robin;
    int ord[4];
`ifdef DDR_ARB_RR_EN
    ord = '{0, 1, 2, 0};
`else
    ord = '{2, 2, 2, 2};
`endif
    do_reset;
    for (int i = 0; i < 3; i++) set_addr(i, 28'(32'h100 * (i + 1)));
    req_rd = 3'b111;
    for (int k = 0; k < 4; k++) begin
      expect_grant("round_robin", ord[k], 1'b0, 28'(32'h100 * (ord[k] + 1)));
      if (k == 3) req_rd = 3'b000;
      serve_burst("round_robin", 1'b0, ord[k], 2, 1'b0, 1'b1);
    end
  endtask

  task automatic test_overrun;
    tick;
    set_addr(0, 28'h0004000);
    req_rd = 3'b001;
    expect_grant("overrun", 0, 1'b0, 28'h0004000);
    req_rd = 3'b000;
    serve_burst("overrun", 1'b0, 0, 17, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL overrun_err: err=%b, want 1", err);
    end
    set_addr(1, 28'h0004100);
    req_wr = 3'b010;
    expect_grant("overrun_next", 1, 1'b1, 28'h0004100);
    req_wr = 3'b000;
    serve_burst("overrun_next", 1'b1, 1, 3, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: err=%b, want 1", err);
    end
    do_reset;
    mid;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: err=%b, want 0", err);
    end
  endtask

  task automatic test_reset_mid_write;
    tick;
    set_addr(0, 28'h0005000);
    req_wr = 3'b001;
    expect_grant("rst_mid_wr", 0, 1'b1, 28'h0005000);
    req_wr = 3'b000;
    serve_burst("rst_mid_wr", 1'b1, 0, 5, 1'b0, 1'b0);
    rst = 1'b1;
    wr_burst_data_req = 1'b1;
    mid;
    tick;
    rst = 1'b0;
    mid;
    checks++;
    if ({gnt, done, wr_data_req, rd_valid, wr_burst_req, rd_burst_req} !== 14'd0 ||
        wr_burst_addr !== '0 || wr_burst_data !== '0) begin
      failures++;
      $display("FAIL rst_mid_wr_outputs: gnt=%b done=%b wdr=%b wreq=%b waddr=%h wdata=%h, want 0",
               gnt, done, wr_data_req, wr_burst_req, wr_burst_addr, wr_burst_data);
    end
    wr_burst_data_req = 1'b0;
    tick;
    mid;
    checks++;
    if (done !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_wr_no_done: done=%b, want 000", done);
    end
    set_addr(2, 28'h0006000);
    req_rd = 3'b100;
    expect_grant("rst_mid_wr_after", 2, 1'b0, 28'h0006000);
    req_rd = 3'b000;
    serve_burst("rst_mid_wr_after", 1'b0, 2, 3, 1'b0, 1'b1);
  endtask

  task automatic test_spurious_finish;
    tick;
    set_addr(1, 28'h0007000);
    req_rd = 3'b010;
    expect_grant("spurious", 1, 1'b0, 28'h0007000);
    req_rd = 3'b000;
    serve_burst("spurious", 1'b0, 1, 3, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_priority;
    test_round_robin;
    test_overrun;
    test_reset_mid_write;
    test_spurious_finish;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
